// File: rtl/sc_game_pkg.sv
// sc_game_pkg: shared widths, default parameters and state encoding for the game controller.
// Ports: none (package).
package sc_game_pkg;
    localparam int LIVES_W = 2;
    localparam int LEVEL_W = 3;
    localparam int CNT_W   = 8;
    localparam int LIVES_INIT_DEF       = 3;
    localparam int SHIFTS_PER_LEVEL_DEF = 16;
    localparam int LEVEL_MAX_DEF        = 4;
    localparam int CRASH_HOLD_DEF       = 8;
    typedef enum logic [3:0] {
        ST_CLEAR    = 4'd0,
        ST_INIT     = 4'd1,
        ST_IDLE     = 4'd2,
        ST_PLAY     = 4'd3,
        ST_SHIFT    = 4'd4,
        ST_CHECK    = 4'd5,
        ST_CRASH    = 4'd6,
        ST_LEVELUP  = 4'd7,
        ST_GAMEOVER = 4'd8,
`ifdef SC_STATEMACHINEGAME_PAUSE_EN
        ST_WIN      = 4'd9,
        ST_PAUSE    = 4'd10
`else
        ST_WIN      = 4'd9
`endif
    } state_e;
endpackage

// File: rtl/sc_edge_detect_low.sv
// sc_edge_detect_low: registered falling-edge detector for an active-low button.
// Ports: clk, rst_n (async active-low), in_low (button), fall (1 on the first low cycle after a high sample).
module sc_edge_detect_low (
    input  logic clk,
    input  logic rst_n,
    input  logic in_low,
    output logic fall
);
    logic prev_q, prev_d;
    always_comb prev_d = in_low;
    // Previous sample resets high so a button already held at reset release counts as one press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b1;
        else        prev_q <= prev_d;
    end
    assign fall = prev_q & ~in_low;
endmodule

// File: rtl/sc_statemachine_game.sv
// sc_statemachine_game: game controller FSM sequencing clear/load/shift of the point/background bank,
// tracking lives and level from the active-low crash flag, declaring game-over or win.
// Ports: CLOCK_50 clock, RESET_InLow async reset, start_InLow button, crash_InLow detector flag,
// tick_InHigh shift pacing; outputs clear/load/shift pulses, lives, level, gameover, win.
// Optional: define SC_STATEMACHINEGAME_PAUSE_EN to add pause_InLow and a PAUSE state.
module sc_statemachine_game
    import sc_game_pkg::*;
#(
    parameter int LIVES_INIT       = LIVES_INIT_DEF,
    parameter int SHIFTS_PER_LEVEL = SHIFTS_PER_LEVEL_DEF,
    parameter int LEVEL_MAX        = LEVEL_MAX_DEF,
    parameter int CRASH_HOLD       = CRASH_HOLD_DEF
) (
    input  logic               SC_STATEMACHINEGAME_CLOCK_50,
    input  logic               SC_STATEMACHINEGAME_RESET_InLow,
    input  logic               SC_STATEMACHINEGAME_start_InLow,
    input  logic               SC_STATEMACHINEGAME_crash_InLow,
    input  logic               SC_STATEMACHINEGAME_tick_InHigh,
`ifdef SC_STATEMACHINEGAME_PAUSE_EN
    input  logic               SC_STATEMACHINEGAME_pause_InLow,
`endif
    output logic               SC_STATEMACHINEGAME_clear_OutHigh,
    output logic               SC_STATEMACHINEGAME_load_OutHigh,
    output logic               SC_STATEMACHINEGAME_shift_OutHigh,
    output logic [LIVES_W-1:0] SC_STATEMACHINEGAME_lives_Out,
    output logic [LEVEL_W-1:0] SC_STATEMACHINEGAME_level_Out,
    output logic               SC_STATEMACHINEGAME_gameover_OutHigh,
    output logic               SC_STATEMACHINEGAME_win_OutHigh
);
    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               start_ev;
    logic               crash;
    logic               tick;
    assign crash = ~SC_STATEMACHINEGAME_crash_InLow;
    assign tick  = SC_STATEMACHINEGAME_tick_InHigh;
    sc_edge_detect_low u_start_edge (
        .clk    (SC_STATEMACHINEGAME_CLOCK_50),
        .rst_n  (SC_STATEMACHINEGAME_RESET_InLow),
        .in_low (SC_STATEMACHINEGAME_start_InLow),
        .fall   (start_ev)
    );
`ifdef SC_STATEMACHINEGAME_PAUSE_EN
    logic pause_ev;
    sc_edge_detect_low u_pause_edge (
        .clk    (SC_STATEMACHINEGAME_CLOCK_50),
        .rst_n  (SC_STATEMACHINEGAME_RESET_InLow),
        .in_low (SC_STATEMACHINEGAME_pause_InLow),
        .fall   (pause_ev)
    );
`endif
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        level_d     = level_q;
        shift_cnt_d = shift_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            ST_CLEAR: state_d = ST_INIT;
            ST_INIT: begin
                shift_cnt_d = '0;
                state_d     = ST_IDLE;
            end
            ST_IDLE: state_d = start_ev ? ST_PLAY : ST_IDLE;
            ST_PLAY: begin
                state_d = crash ? ST_CRASH : tick ? ST_SHIFT : ST_PLAY;
`ifdef SC_STATEMACHINEGAME_PAUSE_EN
                if (pause_ev) state_d = ST_PAUSE;
`endif
            end
            ST_SHIFT: begin
                shift_cnt_d = shift_cnt_q + CNT_W'(1);
                state_d     = ST_CHECK;
            end
            ST_CHECK: state_d = crash ? ST_CRASH :
                                (shift_cnt_q == CNT_W'(SHIFTS_PER_LEVEL)) ? ST_LEVELUP : ST_PLAY;
            ST_CRASH: begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (hold_cnt_q == CNT_W'(CRASH_HOLD - 1))
                    state_d = (lives_q == '0) ? ST_GAMEOVER : ST_CLEAR;
            end
            ST_LEVELUP: begin
                if (level_q == LEVEL_W'(LEVEL_MAX - 1)) state_d = ST_WIN;
                else begin
                    level_d = level_q + LEVEL_W'(1);
                    state_d = ST_CLEAR;
                end
            end
            ST_GAMEOVER, ST_WIN: begin
                if (start_ev) begin
                    lives_d = LIVES_W'(LIVES_INIT);
                    level_d = '0;
                    state_d = ST_CLEAR;
                end
            end
`ifdef SC_STATEMACHINEGAME_PAUSE_EN
            ST_PAUSE: state_d = pause_ev ? ST_PLAY : ST_PAUSE;
`endif
            default: state_d = ST_CLEAR;
        endcase
        // Both PLAY and CHECK can enter CRASH; the life is taken on the entering edge.
        if (state_d == ST_CRASH && state_q != ST_CRASH) begin
            lives_d    = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
            hold_cnt_d = '0;
        end
    end
    always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or negedge SC_STATEMACHINEGAME_RESET_InLow) begin
        if (!SC_STATEMACHINEGAME_RESET_InLow) begin
            state_q     <= ST_CLEAR;
            lives_q     <= LIVES_W'(LIVES_INIT);
            level_q     <= '0;
            shift_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            shift_cnt_q <= shift_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end
    assign SC_STATEMACHINEGAME_clear_OutHigh    = (state_q == ST_CLEAR);
    assign SC_STATEMACHINEGAME_load_OutHigh     = (state_q == ST_INIT);
    assign SC_STATEMACHINEGAME_shift_OutHigh    = (state_q == ST_SHIFT);
    assign SC_STATEMACHINEGAME_gameover_OutHigh = (state_q == ST_GAMEOVER);
    assign SC_STATEMACHINEGAME_win_OutHigh      = (state_q == ST_WIN);
    assign SC_STATEMACHINEGAME_lives_Out        = lives_q;
    assign SC_STATEMACHINEGAME_level_Out        = level_q;
endmodule

// File: tb/tb_sc_statemachine_game.sv
// tb_sc_statemachine_game: scoreboard bench; stimulus queues expected output events, a monitor checks them.
module tb_sc_statemachine_game;
    typedef struct packed {
        logic       clr, ld, sh, go, wn;
        logic [1:0] lives;
        logic [2:0] level;
    } ev_t;
    localparam logic [4:0] K_CLR = 5'b10000;
    localparam logic [4:0] K_LD  = 5'b01000;
    localparam logic [4:0] K_SH  = 5'b00100;
    localparam logic [4:0] K_GO  = 5'b00010;
    localparam logic [4:0] K_WN  = 5'b00001;
    logic clk = 1'b0, rst_n, start_n, crash_n, tick, pause_n;
    logic clr, ld, sh, go, wn;
    logic [1:0] lives;
    logic [2:0] level;
    int checks = 0, failures = 0;
    ev_t exp_q[$];
    always #5 clk = ~clk;
    sc_statemachine_game dut (
        .SC_STATEMACHINEGAME_CLOCK_50        (clk),
        .SC_STATEMACHINEGAME_RESET_InLow     (rst_n),
        .SC_STATEMACHINEGAME_start_InLow     (start_n),
        .SC_STATEMACHINEGAME_crash_InLow     (crash_n),
        .SC_STATEMACHINEGAME_tick_InHigh     (tick),
`ifdef SC_STATEMACHINEGAME_PAUSE_EN
        .SC_STATEMACHINEGAME_pause_InLow     (pause_n),
`endif
        .SC_STATEMACHINEGAME_clear_OutHigh   (clr),
        .SC_STATEMACHINEGAME_load_OutHigh    (ld),
        .SC_STATEMACHINEGAME_shift_OutHigh   (sh),
        .SC_STATEMACHINEGAME_lives_Out       (lives),
        .SC_STATEMACHINEGAME_level_Out       (level),
        .SC_STATEMACHINEGAME_gameover_OutHigh(go),
        .SC_STATEMACHINEGAME_win_OutHigh     (wn)
    );
    task automatic push(input logic [4:0] k, input int lv, input int lvl);
        exp_q.push_back(ev_t'({k, 2'(lv), 3'(lvl)}));
    endtask
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic press();
        start_n = 1'b0;
        cyc(2);
        start_n = 1'b1;
        cyc(1);
    endtask
    task automatic tick_play();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
    endtask
    // Monitor: every clear/load/shift cycle and every gameover/win rising edge is an output event.
    initial begin
        logic go_p, wn_p;
        ev_t act, ex;
        go_p = 1'b0;
        wn_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (clr || ld || sh || (go && !go_p) || (wn && !wn_p))) begin
                act = {clr, ld, sh, go, wn, lives, level};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got=%b exp=none", act);
                end else begin
                    ex = exp_q.pop_front();
                    if (act !== ex) begin
                        failures++;
                        $display("FAIL event got=%b exp=%b", act, ex);
                    end
                end
            end
            go_p = go;
            wn_p = wn;
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
    initial begin
        int cnt;
        rst_n = 1'b0; start_n = 1'b1; crash_n = 1'b1; tick = 1'b0; pause_n = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("rst_clear", int'(clr), 1);
        chk("rst_pulses", int'({ld, sh, go, wn}), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_level", int'(level), 0);
        push(K_CLR, 3, 0); push(K_LD, 3, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(4);
        chk("idle_lives", int'(lives), 3);
        chk("idle_level", int'(level), 0);
        chk("idle_quiet", int'({clr, ld, sh, go, wn}), 0);
        // Held start: one event only; then a full level of shifts.
        start_n = 1'b0;
        cyc(10);
        start_n = 1'b1;
        cyc(1);
        repeat (16) push(K_SH, 3, 0);
        push(K_CLR, 3, 1); push(K_LD, 3, 1);
        repeat (16) tick_play();
        cyc(3);
        chk("levelup_level", int'(level), 1);
        // Crash with simultaneous tick, start held through the crash.
        start_n = 1'b0;
        cyc(2);
        push(K_CLR, 2, 1); push(K_LD, 2, 1);
        crash_n = 1'b0; tick = 1'b1;
        cyc(1);
        crash_n = 1'b1; tick = 1'b0;
        cnt = 0;
        while (!clr && cnt < 50) begin
            @(negedge clk);
            if (!clr) cnt++;
        end
        chk("crash_len", cnt, 8);
        cyc(4);
        tick_play();
        start_n = 1'b1;
        cyc(2);
        // Second crash from PLAY.
        push(K_CLR, 1, 1); push(K_LD, 1, 1);
        press();
        crash_n = 1'b0;
        cyc(1);
        crash_n = 1'b1;
        cyc(12);
        // Third crash caught in CHECK after a shift.
        push(K_SH, 1, 1); push(K_GO, 0, 1);
        press();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
        crash_n = 1'b0;
        cyc(1);
        crash_n = 1'b1;
        cyc(10);
        chk("gameover", int'(go), 1);
        chk("gameover_lives", int'(lives), 0);
        push(K_CLR, 3, 0); push(K_LD, 3, 0);
        press();
        cyc(2);
        // Clear every level to win.
        for (int lv = 0; lv < 4; lv++) begin
            repeat (16) push(K_SH, 3, lv);
            if (lv < 3) begin
                push(K_CLR, 3, lv + 1);
                push(K_LD, 3, lv + 1);
            end else push(K_WN, 3, 3);
            press();
            repeat (16) tick_play();
            cyc(3);
        end
        chk("win", int'(wn), 1);
        chk("win_level", int'(level), 3);
        push(K_CLR, 3, 0); push(K_LD, 3, 0);
        press();
        cyc(2);
        press();
`ifdef SC_STATEMACHINEGAME_PAUSE_EN
        pause_n = 1'b0;
        cyc(1);
        pause_n = 1'b1;
        crash_n = 1'b0;
        repeat (5) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
        crash_n = 1'b1;
        cyc(1);
        chk("pause_lives", int'(lives), 3);
        pause_n = 1'b0;
        cyc(1);
        pause_n = 1'b1;
        push(K_SH, 3, 0);
        tick_play();
`endif
        // Reset in the middle of CRASH.
        crash_n = 1'b0;
        cyc(1);
        crash_n = 1'b1;
        cyc(4);
        chk("crash_lives", int'(lives), 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_clear", int'(clr), 1);
        chk("midrst_pulses", int'({ld, sh, go, wn}), 0);
        chk("midrst_lives", int'(lives), 3);
        chk("midrst_level", int'(level), 0);
        push(K_CLR, 3, 0); push(K_LD, 3, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sc_statemachine_game.md
Name: sc_statemachine_game

Overview:
Game controller FSM that sequences the 8x8 point/background register datapath and its combinational crash detector. It clears and loads the register bank and paces background shifts from a timer tick. It samples the active-low crash flag and tracks lives and level, declaring game-over or win.

Parameters:
LIVES_INIT, 3, lives at game start (legal 1..3)
SHIFTS_PER_LEVEL, 16, background shifts survived before level-up (legal 2..255)
LEVEL_MAX, 4, number of levels; clearing level LEVEL_MAX-1 wins (legal 1..8)
CRASH_HOLD, 8, cycles spent in CRASH before continuing (legal 1..255)

Ports:
SC_STATEMACHINEGAME_CLOCK_50  in  1  system clock
SC_STATEMACHINEGAME_RESET_InLow  in  1  asynchronous active-low reset
SC_STATEMACHINEGAME_start_InLow  in  1  debounced start button, active-low
SC_STATEMACHINEGAME_crash_InLow  in  1  crash flag from detector, 0 = overlap
SC_STATEMACHINEGAME_tick_InHigh  in  1  one-cycle shift-rate pulse from timer
SC_STATEMACHINEGAME_clear_OutHigh  out  1  clear all point/background registers
SC_STATEMACHINEGAME_load_OutHigh  out  1  load initial map for level_Out
SC_STATEMACHINEGAME_shift_OutHigh  out  1  shift background one row
SC_STATEMACHINEGAME_lives_Out  out  2  remaining lives
SC_STATEMACHINEGAME_level_Out  out  3  current level, 0-based
SC_STATEMACHINEGAME_gameover_OutHigh  out  1  game lost
SC_STATEMACHINEGAME_win_OutHigh  out  1  game won

Behaviour:
- Outputs clear/load/shift/gameover/win are Moore decodes of the state register. lives/level/counters are registers.
- Reset (async, low): state=CLEAR, lives=LIVES_INIT, level=0, shift_cnt=0, hold_cnt=0, start_prev=1. Output values during reset: clear=1, others 0.
- Start event: start_InLow==0 while the registered previous sample was 1. A held button produces exactly one event.
- CLEAR: clear=1 for one cycle -> INIT.
- INIT: load=1 for one cycle; shift_cnt=0 -> IDLE.
- IDLE: on start event -> PLAY. Otherwise stay.
- PLAY: crash_InLow==0 -> CRASH (priority over tick). Else tick -> SHIFT. Else stay.
- SHIFT: shift=1 for one cycle; shift_cnt+1 -> CHECK.
- CHECK (one settle cycle for the detector):
  - crash_InLow==0 -> CRASH.
  - Else shift_cnt==SHIFTS_PER_LEVEL -> LEVELUP.
  - Else -> PLAY.
- Ticks arriving in SHIFT/CHECK/CRASH/IDLE are dropped, not queued.
- Entry into CRASH: lives decrements in the transition cycle, saturating at 0. hold_cnt=0.
- CRASH: hold_cnt increments each cycle. At hold_cnt==CRASH_HOLD-1:
  - lives==0 -> GAMEOVER.
  - Else -> CLEAR (same level reloaded; player waits for start in IDLE).
- LEVELUP (one cycle):
  - level==LEVEL_MAX-1 -> WIN.
  - Else level+1 -> CLEAR.
- GAMEOVER (gameover=1) / WIN (win=1): on start event, lives=LIVES_INIT, level=0 -> CLEAR.
- Reset asserted in any state aborts immediately to reset values. No partial shift/load pulse may extend past reset assertion.
- State encoding: one-hot or binary, implementer's choice; unreachable codes -> CLEAR.

Optional Feature:
Macro SC_STATEMACHINEGAME_PAUSE_EN.
- Defined: adds input SC_STATEMACHINEGAME_pause_InLow (1 bit, active-low) with its own falling-edge event detection, and a PAUSE state.
  - A pause event in PLAY -> PAUSE.
  - In PAUSE, tick and crash are ignored.
  - A pause event in PAUSE -> PLAY.
  - Pause events are ignored in all other states.
- Undefined: no port, no PAUSE state; behaviour exactly as above.

Decomposition:
- Package sc_game_pkg: state encoding localparams, default parameter constants, and widths (LIVES_W=2, LEVEL_W=3, CNT_W=8).
- One sub-module, sc_edge_detect_low: registered falling-edge detector with async active-low reset. Instantiated for start, and for pause when enabled.

Test Plan:
- Reset release -> clear=1 for 1 cycle, then load=1 for 1 cycle, then IDLE. Check lives=3, level=0.
- Start held low for 10 cycles -> exactly one IDLE->PLAY. Back in IDLE after a crash, a still-held start does not restart.
- In PLAY, 16 ticks with crash_InLow=1 -> 16 shift pulses, LEVELUP, level=1, then clear and load pulses.
- crash_InLow=0 in the same cycle as tick in PLAY -> no shift pulse. Lives 3->2, 8 cycles in CRASH, then CLEAR.
- Three crashes -> lives=0, gameover=1. A start event -> lives=3, level=0, clear pulse.
- Reset asserted mid-CRASH at hold_cnt=4 -> outputs at reset values immediately. With PAUSE_EN, a pause event in PLAY suppresses 5 ticks and crash=0, then a second pause event resumes PLAY.
